i2c_cmd_sequencer: RTL

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_cmd_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands, hands them one at a time to a byte-level I2C master,
// and returns one response per command (data, NACK or timeout) in order.
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16384
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_r_w,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic                     rsp_r_w,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     m_new_dat,
  output logic [6:0]               m_addr,
  output logic                     m_r_w,
  output logic [7:0]               m_dat_in,
  input  logic [7:0]               m_dat_out,
  input  logic                     m_busy,
  input  logic                     m_ack_err,
  input  logic                     m_done,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic [1:0]               fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RETIRE} state_t;
  state_t state;

  // Both queues use valid/ready: a transfer happens on any rising edge where
  // valid and ready are both high; valid never depends on ready.
  logic [15:0]   cmd_mem [DEPTH];
  logic [AW-1:0] cmd_wp, cmd_rp;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_full, cmd_push, cmd_pop;
  logic [15:0]   cmd_head;

  logic [10:0]   rsp_mem [DEPTH];
  logic [AW-1:0] rsp_wp, rsp_rp;
  logic [CW-1:0] rsp_cnt;
  logic          rsp_full, rsp_push, rsp_pop;
  logic [10:0]   rsp_wdata;

  logic [TW-1:0] tcnt;
  logic          in_txn, done_hit, to_hit;

  assign cmd_full  = (cmd_cnt == CW'(DEPTH));
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign rsp_full  = (rsp_cnt == CW'(DEPTH));
  assign cmd_pop   = (state == IDLE) && (cmd_cnt != '0) && !rsp_full;
  assign cmd_head  = cmd_mem[cmd_rp];
  assign cmd_count = cmd_cnt;

  assign rsp_valid = (rsp_cnt != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign {rsp_data, rsp_r_w, rsp_err, rsp_timeout} = rsp_mem[rsp_rp];

  // A done pulse on the final timeout cycle still counts as a completion.
  assign in_txn    = (state == ISSUE) || (state == WAIT_DONE);
  assign done_hit  = in_txn && m_done;
  assign to_hit    = in_txn && !m_done && (tcnt == T_LAST);
  assign rsp_push  = done_hit || to_hit;
  assign rsp_wdata = done_hit ? {(m_r_w ? m_dat_out : 8'h00), m_r_w, m_ack_err, 1'b0}
                              : {8'h00, m_r_w, 1'b1, 1'b1};

  assign idle      = (state == IDLE) && (cmd_cnt == '0);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_r_w, cmd_addr, cmd_data};
    if (rsp_push) rsp_mem[rsp_wp] <= rsp_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + AW'(1);
      if (cmd_pop)  cmd_rp <= cmd_rp + AW'(1);
      cmd_cnt <= cmd_cnt + CW'(cmd_push) - CW'(cmd_pop);
      if (rsp_push) rsp_wp <= rsp_wp + AW'(1);
      if (rsp_pop)  rsp_rp <= rsp_rp + AW'(1);
      rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);
    end
  end

  // m_addr/m_r_w/m_dat_in double as the holding register for the command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_new_dat <= 1'b0;
      m_addr    <= '0;
      m_r_w     <= 1'b0;
      m_dat_in  <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_pop) begin
            {m_r_w, m_addr, m_dat_in} <= cmd_head;
            m_new_dat <= 1'b1;
            tcnt      <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT_DONE: begin
          tcnt <= tcnt + TW'(1);
          if (rsp_push) begin
            m_new_dat <= 1'b0;
            state     <= RETIRE;
          end else if ((state == ISSUE) && m_busy) begin
            m_new_dat <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        RETIRE: begin
          if (!m_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
